// File: rtl/inst_cache_pkg.sv
// Shared sizing, FSM encoding and helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int unsigned IC_ADDR_WIDTH      = 32;
    localparam int unsigned IC_INDEX_WIDTH_DEF = 6;

    typedef enum logic {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } ic_state_e;

    // Tag width left over once the word offset and line index are stripped.
    function automatic int unsigned ic_tag_width(input int unsigned index_w);
        return IC_ADDR_WIDTH - index_w - 2;
    endfunction

endpackage

// File: rtl/inst_cache_line_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
// Valid bits are flops so a single reset cycle empties the cache.
module inst_cache_line_array
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_W = IC_INDEX_WIDTH_DEF,
    parameter int unsigned TAG_W   = ic_tag_width(IC_INDEX_WIDTH_DEF)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [31:0]        rd_data_o,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [31:0]        wr_data_i
);

    localparam int unsigned LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// refill. Hits are answered combinationally for whatever PC is presented.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned IC_INDEX_WIDTH = IC_INDEX_WIDTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic [31:0] iu_to_ic_pc,
    output logic        ic_to_iu_ready,
    output logic [31:0] ic_to_iu_inst,
    output logic        ic_to_mc_valid,
    output logic [31:0] ic_to_mc_addr,
    input  logic        mc_to_ic_ready,
    input  logic [31:0] mc_to_ic_inst
);

    localparam int unsigned TAG_W = ic_tag_width(IC_INDEX_WIDTH);

    ic_state_e   state_q;
    logic        mc_valid_q;
    logic [31:0] mc_addr_q;

    logic [IC_INDEX_WIDTH-1:0] rd_idx;
    logic [TAG_W-1:0]          pc_tag;
    logic                      rd_valid;
    logic [TAG_W-1:0]          rd_tag;
    logic [31:0]               rd_data;
    logic                      hit;
    logic                      fill_en;

    assign rd_idx = iu_to_ic_pc[IC_INDEX_WIDTH+1:2];
    assign pc_tag = iu_to_ic_pc[31:IC_INDEX_WIDTH+2];

    assign hit     = rd_valid && (rd_tag == pc_tag) && rdy_in && !rst_in;
    assign fill_en = (state_q == IC_FETCH) && mc_to_ic_ready && rdy_in && !rst_in;

    inst_cache_line_array #(
        .INDEX_W (IC_INDEX_WIDTH),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_en),
        .wr_idx_i   (mc_addr_q[IC_INDEX_WIDTH+1:2]),
        .wr_tag_i   (mc_addr_q[31:IC_INDEX_WIDTH+2]),
        .wr_data_i  (mc_to_ic_inst)
    );

    // Refill FSM; the request address register doubles as the fill target.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IC_IDLE;
            mc_valid_q <= 1'b0;
            mc_addr_q  <= '0;
        end else if (rdy_in) begin
            case (state_q)
                IC_IDLE: begin
                    if (!hit && !clr_in) begin
                        state_q    <= IC_FETCH;
                        mc_valid_q <= 1'b1;
                        mc_addr_q  <= iu_to_ic_pc & 32'hFFFF_FFFC;
                    end
                end
                IC_FETCH: begin
                    // A flush never cancels: the controller cannot abort a read.
                    if (mc_to_ic_ready) begin
                        state_q    <= IC_IDLE;
                        mc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IC_IDLE;
                    mc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ic_to_iu_ready = hit;
    assign ic_to_iu_inst  = hit ? rd_data : 32'h0;
    assign ic_to_mc_valid = mc_valid_q;
    assign ic_to_mc_addr  = mc_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed vector table, randomized run
// against an address-keyed reference model, and a bounded refill handshake.
module tb_inst_cache;

    localparam int unsigned IW    = 6;
    localparam int unsigned LINES = 2 ** IW;

    logic        clk;
    logic        rst_in, rdy_in, clr_in;
    logic [31:0] pc;
    logic        ic_ready;
    logic [31:0] ic_inst;
    logic        mc_valid;
    logic [31:0] mc_addr;
    logic        mc_ready;
    logic [31:0] mc_inst;

    inst_cache #(.IC_INDEX_WIDTH(IW)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clr_in         (clr_in),
        .iu_to_ic_pc    (pc),
        .ic_to_iu_ready (ic_ready),
        .ic_to_iu_inst  (ic_inst),
        .ic_to_mc_valid (mc_valid),
        .ic_to_mc_addr  (mc_addr),
        .mc_to_ic_ready (mc_ready),
        .mc_to_ic_inst  (mc_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rst, rdy, clr;
        logic [31:0] pc;
        logic        mcr;
        logic [31:0] mci;
        logic        er;
        logic [31:0] ei;
        logic        ev;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[40];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    // Reference model: each line remembers the full word address it holds.
    logic        m_valid [LINES];
    logic [31:0] m_line  [LINES];
    logic [31:0] m_data  [LINES];
    logic        m_pend;
    logic [31:0] m_paddr;

    function automatic vec_t mk(logic rst, logic rdy, logic clr, logic [31:0] p, logic mcr,
                                logic [31:0] mci, logic er, logic [31:0] ei, logic ev,
                                logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.clr = clr; v.pc = p; v.mcr = mcr; v.mci = mci;
        v.er = er; v.ei = ei; v.ev = ev; v.ea = ea;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive(input logic rst, input logic rdy, input logic clr, input logic [31:0] p,
                         input logic mcr, input logic [31:0] mci);
        rst_in = rst; rdy_in = rdy; clr_in = clr; pc = p; mc_ready = mcr; mc_inst = mci;
    endtask

    task automatic check(input string name, input logic er, input logic [31:0] ei,
                         input logic ev, input logic [31:0] ea);
        vec_cnt++;
        if (ic_ready !== er || ic_inst !== ei || mc_valid !== ev || mc_addr !== ea) begin
            miss_cnt++;
            $display("FAIL %s pc=%h: got ready=%b inst=%h mc_valid=%b mc_addr=%h, expected ready=%b inst=%h mc_valid=%b mc_addr=%h",
                     name, pc, ic_ready, ic_inst, mc_valid, mc_addr, er, ei, ev, ea);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(LINES); i++) begin
            m_valid[i] = 1'b0;
            m_line[i]  = '0;
            m_data[i]  = '0;
        end
        m_pend  = 1'b0;
        m_paddr = '0;
    endtask

    initial begin
        logic [31:0] tagpart, rpc, rmci, ei;
        logic        rrst, rrdy, rclr, rmcr, er;
        int          idx, n;

        tbl[0]  = mk(1,1,0,32'h000,0,32'h0,        0,32'h0,        0,32'h000);
        tbl[1]  = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        0,32'h000);
        tbl[2]  = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        1,32'h000);
        tbl[3]  = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        1,32'h000);
        tbl[4]  = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        1,32'h000);
        tbl[5]  = mk(0,1,0,32'h000,1,32'h13,       0,32'h0,        1,32'h000);
        tbl[6]  = mk(0,1,0,32'h000,0,32'h0,        1,32'h13,       0,32'h000);
        tbl[7]  = mk(0,1,0,32'h004,0,32'h0,        0,32'h0,        0,32'h000);
        tbl[8]  = mk(0,1,0,32'h006,0,32'h0,        0,32'h0,        1,32'h004);
        tbl[9]  = mk(0,1,0,32'h006,1,32'hAAAA0001, 0,32'h0,        1,32'h004);
        tbl[10] = mk(0,1,0,32'h006,0,32'h0,        1,32'hAAAA0001, 0,32'h004);
        tbl[11] = mk(0,1,0,32'h004,0,32'h0,        1,32'hAAAA0001, 0,32'h004);
        tbl[12] = mk(0,1,0,32'h000,0,32'h0,        1,32'h13,       0,32'h004);
        tbl[13] = mk(0,1,0,32'h100,0,32'h0,        0,32'h0,        0,32'h004);
        tbl[14] = mk(0,1,0,32'h100,0,32'h0,        0,32'h0,        1,32'h100);
        tbl[15] = mk(0,1,0,32'h100,1,32'hBBBB0100, 0,32'h0,        1,32'h100);
        tbl[16] = mk(0,1,0,32'h100,0,32'h0,        1,32'hBBBB0100, 0,32'h100);
        tbl[17] = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        0,32'h100);
        tbl[18] = mk(0,1,0,32'h000,0,32'h0,        0,32'h0,        1,32'h000);
        tbl[19] = mk(0,1,0,32'h000,1,32'h13,       0,32'h0,        1,32'h000);
        tbl[20] = mk(0,1,0,32'h000,0,32'h0,        1,32'h13,       0,32'h000);
        tbl[21] = mk(0,1,0,32'h040,0,32'h0,        0,32'h0,        0,32'h000);
        tbl[22] = mk(0,1,1,32'h080,0,32'h0,        0,32'h0,        1,32'h040);
        tbl[23] = mk(0,1,1,32'h080,0,32'h0,        0,32'h0,        1,32'h040);
        tbl[24] = mk(0,1,0,32'h080,1,32'hCCCC0040, 0,32'h0,        1,32'h040);
        tbl[25] = mk(0,1,0,32'h080,0,32'h0,        0,32'h0,        0,32'h040);
        tbl[26] = mk(0,1,0,32'h040,0,32'h0,        1,32'hCCCC0040, 1,32'h080);
        tbl[27] = mk(0,1,0,32'h080,1,32'hDDDD0080, 0,32'h0,        1,32'h080);
        tbl[28] = mk(0,1,0,32'h080,0,32'h0,        1,32'hDDDD0080, 0,32'h080);
        tbl[29] = mk(0,1,1,32'h0C0,0,32'h0,        0,32'h0,        0,32'h080);
        tbl[30] = mk(0,1,0,32'h0C0,0,32'h0,        0,32'h0,        0,32'h080);
        tbl[31] = mk(0,0,0,32'h0C0,1,32'h00000BAD, 0,32'h0,        1,32'h0C0);
        tbl[32] = mk(0,0,0,32'h080,0,32'h0,        0,32'h0,        1,32'h0C0);
        tbl[33] = mk(0,1,0,32'h0C0,1,32'hEEEE00C0, 0,32'h0,        1,32'h0C0);
        tbl[34] = mk(0,1,0,32'h0C0,0,32'h0,        1,32'hEEEE00C0, 0,32'h0C0);
        tbl[35] = mk(0,1,0,32'h200,0,32'h0,        0,32'h0,        0,32'h0C0);
        tbl[36] = mk(1,1,0,32'h200,0,32'h0,        0,32'h0,        1,32'h200);
        tbl[37] = mk(0,1,1,32'h200,1,32'h12345678, 0,32'h0,        0,32'h000);
        tbl[38] = mk(0,1,1,32'h000,0,32'h0,        0,32'h0,        0,32'h000);
        tbl[39] = mk(0,1,1,32'h040,0,32'h0,        0,32'h0,        0,32'h000);

        drive(1, 1, 0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].clr, tbl[i].pc, tbl[i].mcr, tbl[i].mci);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].er, tbl[i].ei, tbl[i].ev, tbl[i].ea);
            @(posedge clk);
            #1;
        end

        // Randomized traffic on a few conflicting indices against the model.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rrst = ($urandom_range(0, 99) == 0);
            rrdy = ($urandom_range(0, 7) != 0);
            rclr = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 2))
                0:       tagpart = 32'h0000_0000;
                1:       tagpart = 32'h0000_0100;
                default: tagpart = 32'h0004_0000;
            endcase
            rpc  = tagpart | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            rmcr = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rmci = m_pend ? mem_word(m_paddr) : $urandom;

            idx = int'((rpc >> 2) % LINES);
            er  = !rrst && rrdy && m_valid[idx] && (m_line[idx] == (rpc & 32'hFFFF_FFFC));
            ei  = er ? m_data[idx] : 32'h0;

            drive(rrst, rrdy, rclr, rpc, rmcr, rmci);
            @(negedge clk);
            check("rand", er, ei, m_pend, m_paddr);

            if (rrst) begin
                model_reset();
            end else if (rrdy) begin
                if (m_pend) begin
                    if (rmcr) begin
                        idx          = int'((m_paddr >> 2) % LINES);
                        m_valid[idx] = 1'b1;
                        m_line[idx]  = m_paddr;
                        m_data[idx]  = rmci;
                        m_pend       = 1'b0;
                    end
                end else if (!er && !rclr) begin
                    m_pend  = 1'b1;
                    m_paddr = rpc & 32'hFFFF_FFFC;
                end
            end
            @(posedge clk);
            #1;
        end

        // Refill handshake with a bounded wait for the request.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 32'h3FC, 0, 32'h0);
        n = 0;
        while (mc_valid !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (mc_valid !== 1'b1) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL hs_timeout: got mc_valid=%b after %0d cycles, expected 1", mc_valid, n);
        end
        @(negedge clk);
        check("hs_req", 1'b0, 32'h0, 1'b1, 32'h3FC);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 32'h3FE, 1, 32'hFACE0001);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 32'h3FE, 0, 32'h0);
        @(negedge clk);
        check("hs_hit", 1'b1, 32'hFACE0001, 1'b0, 32'h3FC);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
